cpu_run_controller: RTL and testbench

//   Parametrised run/stop controller for the MIPS datapath, placed between the bench or top level and the core.
//   - Sequences core reset, gates the core with a clock enable and counts executed cycles.
//   - Halts on a cycle budget, on PC breakpoints or on an explicit stop request.
//   - Supports single-step and resume, replacing fixed hand-counted clock runs.

---
 rtl/cpu_run_controller.sv | 163 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/stop controller sequencing core reset, clock enable, breakpoints and cycle budget
//
// Ports:
//   clk, reset        system clock (rising edge), async active-high reset
//   start             pulse: reset core, clear cycle counter, then run
//   resume            pulse: continue from HALTED without core reset (passes current bp once)
//   step              pulse: execute exactly one core cycle from HALTED
//   stop              pulse: halt at end of current RUN cycle
//   max_cycles        cycle budget, 0 = unlimited
//   pc                current core PC
//   bp_addr, bp_en    breakpoint addresses (bp i at [i*PC_W +: PC_W]) and enables
//   core_en           core clock enable
//   core_reset        registered synchronous reset to the core
//   running, halted   status decoded from state
//   halt_cause        0 none, 1 budget, 2 breakpoint, 3 stop, 4 step done
//   bp_index          lowest-index breakpoint that caused the halt
//   cycle_count       enabled core cycles since last start, saturating
module cpu_run_controller #(
    parameter int CYCLE_W    = 32,
    parameter int PC_W       = 32,
    parameter int NUM_BP     = 2,
    parameter int RESET_HOLD = 2,
    localparam int BPI_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   resume,
    input  logic                   step,
    input  logic                   stop,
    input  logic [CYCLE_W-1:0]     max_cycles,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   core_en,
    output logic                   core_reset,
    output logic                   running,
    output logic                   halted,
    output logic [2:0]             halt_cause,
    output logic [BPI_W-1:0]       bp_index,
    output logic [CYCLE_W-1:0]     cycle_count
);
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic [2:0]        cause_n;
    logic [BPI_W-1:0]  bpi_n, bp_idx_c;
    logic              bp_skip, skip_n;
    logic              clr_count;
    logic              bp_match, bp_hit;
    logic              budget_done, budget_last;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        bp_match = 1'b0;
        bp_idx_c = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) begin
                bp_match = 1'b1;
                bp_idx_c = BPI_W'(i);
            end
        end
    end

    assign bp_hit      = bp_match && !bp_skip;
    assign budget_done = (max_cycles != '0) && (cycle_count >= max_cycles);
    // The cycle that brings the count up to the budget is the last one allowed.
    assign budget_last = (max_cycles != '0) && ((cycle_count + CYCLE_W'(1)) == max_cycles);

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        cause_n    = halt_cause;
        bpi_n      = bp_index;
        skip_n     = bp_skip;
        clr_count  = 1'b0;
        core_en    = 1'b0;

        case (state)
            S_IDLE: begin
                // Only start leaves IDLE; handled below.
            end
            S_RST_HOLD: begin
                if (hold_cnt == '0) state_n = S_RUN;
                else                hold_cnt_n = hold_cnt - HOLD_W'(1);
            end
            S_RUN: begin
                core_en = !bp_hit && !budget_done;
                if (core_en) skip_n = 1'b0;
                if (stop) begin
                    state_n = S_HALTED;
                    cause_n = 3'd3;
                end else if (bp_hit) begin
                    state_n = S_HALTED;
                    cause_n = 3'd2;
                    bpi_n   = bp_idx_c;
                end else if (budget_done || (core_en && budget_last)) begin
                    state_n = S_HALTED;
                    cause_n = 3'd1;
                end
            end
            S_STEP: begin
                core_en = 1'b1;
                state_n = S_HALTED;
                cause_n = 3'd4;
            end
            S_HALTED: begin
                if (step && !budget_done) begin
                    state_n = S_STEP;
                end else if (resume && !budget_done) begin
                    state_n = S_RUN;
                    skip_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // start overrides everything, from any state.
        if (start) begin
            state_n    = S_RST_HOLD;
            hold_cnt_n = HOLD_LOAD;
            cause_n    = 3'd0;
            skip_n     = 1'b0;
            clr_count  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            halt_cause  <= 3'd0;
            bp_index    <= '0;
            bp_skip     <= 1'b0;
            core_reset  <= 1'b1;
            cycle_count <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            halt_cause <= cause_n;
            bp_index   <= bpi_n;
            bp_skip    <= skip_n;
            core_reset <= (state_n == S_IDLE) || (state_n == S_RST_HOLD);
            if (clr_count)
                cycle_count <= '0;
            else if (core_en && cycle_count != '1)
                cycle_count <= cycle_count + CYCLE_W'(1);
        end
    end

    assign running = (state == S_RUN) || (state == S_STEP);
    assign halted  = (state == S_HALTED);
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - self-checking bench for cpu_run_controller
module tb_cpu_run_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, resume = 1'b0, step = 1'b0, stop = 1'b0;
    logic [31:0] max_cycles = '0;
    logic [31:0] pc = '0;
    logic [63:0] bp_addr = '0;
    logic [1:0]  bp_en = '0;
    logic        core_en, core_reset, running, halted;
    logic [2:0]  halt_cause;
    logic [0:0]  bp_index;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;
    int en_total = 0;
    int rst_total = 0;
    int exp_count = 0;

    cpu_run_controller #(.CYCLE_W(32), .PC_W(32), .NUM_BP(2), .RESET_HOLD(2)) dut (
        .clk(clk), .reset(reset), .start(start), .resume(resume), .step(step), .stop(stop),
        .max_cycles(max_cycles), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
        .core_en(core_en), .core_reset(core_reset), .running(running), .halted(halted),
        .halt_cause(halt_cause), .bp_index(bp_index), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // One clock cycle, entered just after a falling edge. Acts as the core:
    // PC returns to 0 under core_reset and advances by 4 per enabled cycle.
    task automatic tick();
        logic en_s, rs_s;
        #1;
        en_s = core_en;
        rs_s = core_reset;
        en_total  += int'(en_s);
        rst_total += int'(rs_s);
        @(posedge clk);
        #1;
        if (rs_s)      pc = '0;
        else if (en_s) pc = pc + 32'd4;
        @(negedge clk);
    endtask

    task automatic run_until_halt(input int limit, output bit timed_out);
        int i;
        i = 0;
        while (!halted && i < limit) begin
            tick();
            i++;
        end
        timed_out = !halted;
    endtask

    task automatic test_reset();
        n_cmp++; if (core_en !== 1'b0)     begin n_bad++; $display("FAIL reset_core_en got %b want 0", core_en); end
        n_cmp++; if (core_reset !== 1'b1)  begin n_bad++; $display("FAIL reset_core_reset got %b want 1", core_reset); end
        n_cmp++; if (running !== 1'b0)     begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
        n_cmp++; if (halted !== 1'b0)      begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
        n_cmp++; if (halt_cause !== 3'd0)  begin n_bad++; $display("FAIL reset_cause got %0d want 0", halt_cause); end
        n_cmp++; if (bp_index !== 1'b0)    begin n_bad++; $display("FAIL reset_bp_index got %0d want 0", bp_index); end
        n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    endtask

    task automatic test_budget();
        bit to;
        int n, e0, r0;
        bp_en = '0;
        for (int it = 0; it < 3; it++) begin
            n = int'($urandom_range(1, 12));
            max_cycles = n;
            start = 1'b1; tick(); start = 1'b0;
            e0 = en_total; r0 = rst_total;
            run_until_halt(100, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL budget_timeout got running want halted"); end
            n_cmp++; if (en_total - e0 !== n) begin n_bad++; $display("FAIL budget_en_cycles got %0d want %0d", en_total - e0, n); end
            n_cmp++; if (rst_total - r0 !== 2) begin n_bad++; $display("FAIL budget_reset_hold got %0d want 2", rst_total - r0); end
            n_cmp++; if (halt_cause !== 3'd1) begin n_bad++; $display("FAIL budget_cause got %0d want 1", halt_cause); end
            n_cmp++; if (cycle_count !== 32'(n)) begin n_bad++; $display("FAIL budget_count got %0d want %0d", cycle_count, n); end
        end
    endtask

    // Two breakpoints on random word addresses; the one reached first (lower
    // address, ties to index 0) must halt the core before that PC executes.
    task automatic test_breakpoint(output int kmin, output int imin);
        bit to;
        int k0, k1;
        k0 = int'($urandom_range(1, 10));
        k1 = int'($urandom_range(1, 10));
        if (k1 < k0) begin kmin = k1; imin = 1; end
        else         begin kmin = k0; imin = 0; end
        max_cycles = 0;
        bp_addr = {32'(k1 * 4), 32'(k0 * 4)};
        bp_en = 2'b11;
        start = 1'b1; tick(); start = 1'b0;
        run_until_halt(100, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL bp_timeout got running want halted"); end
        n_cmp++; if (pc !== 32'(kmin * 4)) begin n_bad++; $display("FAIL bp_pc got %h want %h", pc, kmin * 4); end
        n_cmp++; if (halt_cause !== 3'd2) begin n_bad++; $display("FAIL bp_cause got %0d want 2", halt_cause); end
        n_cmp++; if (bp_index !== 1'(imin)) begin n_bad++; $display("FAIL bp_index got %0d want %0d", bp_index, imin); end
        n_cmp++; if (cycle_count !== 32'(kmin)) begin n_bad++; $display("FAIL bp_count got %0d want %0d", cycle_count, kmin); end
        exp_count = kmin;
    endtask

    task automatic test_resume_stop(input int kmin, input int imin);
        int m, e0;
        m = int'($urandom_range(1, 6));
        bp_en = (imin == 0) ? 2'b01 : 2'b10;
        e0 = en_total;
        resume = 1'b1; tick(); resume = 1'b0;
        for (int i = 0; i < m; i++) tick();
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL resume_running got %b want 1", running); end
        stop = 1'b1; tick(); stop = 1'b0;
        exp_count = kmin + m + 1;
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL stop_halted got %b want 1", halted); end
        n_cmp++; if (halt_cause !== 3'd3) begin n_bad++; $display("FAIL stop_cause got %0d want 3", halt_cause); end
        n_cmp++; if (en_total - e0 !== m + 1) begin n_bad++; $display("FAIL stop_en_cycles got %0d want %0d", en_total - e0, m + 1); end
        n_cmp++; if (cycle_count !== 32'(exp_count)) begin n_bad++; $display("FAIL stop_count got %0d want %0d", cycle_count, exp_count); end
        n_cmp++; if (pc !== 32'(exp_count * 4)) begin n_bad++; $display("FAIL stop_pc got %h want %h", pc, exp_count * 4); end
    endtask

    task automatic test_step();
        int e0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; tick(); step = 1'b0;
            e0 = en_total;
            tick();
            n_cmp++; if (en_total - e0 !== 1) begin n_bad++; $display("FAIL step_pulse got %0d want 1", en_total - e0); end
            n_cmp++; if (halted !== 1'b1 || halt_cause !== 3'd4) begin n_bad++; $display("FAIL step_cause got halted=%b cause=%0d want halted=1 cause=4", halted, halt_cause); end
            tick();
        end
        exp_count += 3;
        n_cmp++; if (cycle_count !== 32'(exp_count)) begin n_bad++; $display("FAIL step_count got %0d want %0d", cycle_count, exp_count); end
    endtask

    task automatic test_budget_ignore();
        bit to;
        int e0;
        bp_en = '0;
        max_cycles = 5;
        start = 1'b1; tick(); start = 1'b0;
        run_until_halt(100, to);
        n_cmp++; if (to || cycle_count !== 32'd5) begin n_bad++; $display("FAIL ign_first_run got count=%0d timeout=%b want count=5", cycle_count, to); end
        e0 = en_total;
        resume = 1'b1; tick(); resume = 1'b0; tick(); tick();
        step = 1'b1; tick(); step = 1'b0; tick(); tick();
        n_cmp++; if (en_total !== e0) begin n_bad++; $display("FAIL ign_core_en got %0d pulses want 0", en_total - e0); end
        n_cmp++; if (halted !== 1'b1 || cycle_count !== 32'd5) begin n_bad++; $display("FAIL ign_state got halted=%b count=%0d want halted=1 count=5", halted, cycle_count); end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL ign_restart_clear got %0d want 0", cycle_count); end
        e0 = en_total;
        run_until_halt(100, to);
        n_cmp++; if (to || en_total - e0 !== 5 || cycle_count !== 32'd5) begin n_bad++; $display("FAIL ign_rerun got en=%0d count=%0d want 5/5", en_total - e0, cycle_count); end
    endtask

    task automatic test_async_reset();
        max_cycles = 0;
        bp_en = '0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (core_en !== 1'b1 || running !== 1'b1) begin n_bad++; $display("FAIL arst_pre got core_en=%b running=%b want 1/1", core_en, running); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (core_en !== 1'b0 || core_reset !== 1'b1) begin n_bad++; $display("FAIL arst_outputs got core_en=%b core_reset=%b want 0/1", core_en, core_reset); end
        n_cmp++; if (running !== 1'b0 || halted !== 1'b0 || cycle_count !== 32'd0) begin n_bad++; $display("FAIL arst_state got running=%b halted=%b count=%0d want 0/0/0", running, halted, cycle_count); end
        @(negedge clk);
        reset = 1'b0;
        pc = '0;
        tick();
        n_cmp++; if (core_en !== 1'b0 || core_reset !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL arst_idle got core_en=%b core_reset=%b running=%b want 0/1/0", core_en, core_reset, running); end
    endtask

    initial begin
        int kmin, imin;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_budget();
        test_breakpoint(kmin, imin);
        test_resume_stop(kmin, imin);
        test_step();
        test_budget_ignore();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want summary");
        $fatal(1);
    end
endmodule
